// File: rtl/dmem_responder.sv
// dmem_responder: single-port 16-bit word memory behind a req/ready/ack
// handshake with a fixed LATENCY from accept to ack.
// Optional macro DMEM_WBUF_EN adds a one-entry posted write buffer: writes
// ack after one cycle and commit to the array LATENCY cycles after accept.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [15:0] rdata
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  wr_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [DEPTH_LOG2-1:0] idx_in;
   logic                  accept;
   logic                  posted;
   logic                  done;
   logic [15:0]           rd_val;
   logic                  unused_addr;

   logic [15:0] mem [DEPTH];

   // word index wraps; byte-select and upper address bits are dropped
   assign idx_in      = addr[DEPTH_LOG2:1];
   assign unused_addr = ^addr;

   assign accept = req & ready;
   assign ack    = (state == RESP);
   // last WAIT cycle: the edge that ends it enters RESP
   assign done   = (state == WAIT) && (cnt == 4'd0);

`ifdef DMEM_WBUF_EN
   logic                  wbuf_vld;
   logic [DEPTH_LOG2-1:0] wbuf_idx;
   logic [15:0]           wbuf_data;
   logic [3:0]            wbuf_cnt;
   logic                  wbuf_commit;

   assign wbuf_commit = wbuf_vld && (wbuf_cnt == 4'd0);
   // a second write waits for the buffer to drain; reads are never held
   assign ready  = (state != WAIT) && !(req && wr && wbuf_vld);
   assign posted = wr;
   // forward the buffered word if it has not reached the array yet
   assign rd_val = (wbuf_vld && (wbuf_idx == idx_q)) ? wbuf_data : mem[idx_q];

   // posted write buffer: load on write accept, count down to commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbuf_vld  <= 1'b0;
         wbuf_idx  <= '0;
         wbuf_data <= '0;
         wbuf_cnt  <= '0;
      end else if (accept && wr) begin
         wbuf_vld  <= 1'b1;
         wbuf_idx  <= idx_in;
         wbuf_data <= wdata;
         wbuf_cnt  <= CNT_INIT;
      end else if (wbuf_vld) begin
         if (wbuf_cnt == 4'd0) wbuf_vld <= 1'b0;
         else                  wbuf_cnt <= wbuf_cnt - 4'd1;
      end
   end

   // array write happens only when the buffer commits
   always_ff @(posedge clk) begin
      if (wbuf_commit) mem[wbuf_idx] <= wbuf_data;
   end
`else
   logic [15:0] wdata_q;

   assign ready  = (state != WAIT);
   assign posted = 1'b0;
   assign rd_val = mem[idx_q];

   // capture write data with the request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        wdata_q <= '0;
      else if (accept) wdata_q <= wdata;
   end

   // array write on the edge entering RESP; reset keeps state out of WAIT
   always_ff @(posedge clk) begin
      if (done && wr_q) mem[idx_q] <= wdata_q;
   end
`endif

   // next-state logic: accept from IDLE/RESP, count down in WAIT
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (posted) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, counter and latched request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         wr_q  <= 1'b0;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            wr_q  <= wr;
            idx_q <= idx_in;
         end
      end
   end

   // read data is only non-zero during the RESP cycle of a read
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              rdata <= '0;
      else if (done && !wr_q) rdata <= rd_val;
      else                   rdata <= '0;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 16-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 4, giving the number of cycles from request acceptance to ack; legal range is 1..15.
REQ-003 SHALL have port clk, input, width 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, width 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have port req, input, width 1, indicating that the initiator presents a memory request.
REQ-006 SHALL have port wr, input, width 1: 1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr, input, width 16, a byte address; addr[0] is ignored and the word index is addr[DEPTH_LOG2:1], with upper bits ignored (wrap).
REQ-008 SHALL have port wdata, input, width 16, the write data; sampled with req.
REQ-009 SHALL have port ready, output, width 1, indicating that the responder can accept a request this cycle.
REQ-010 SHALL have port ack, output, width 1, a one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, width 16, the read data; valid only while ack=1 for a read.

Function
REQ-012 SHALL accept a request on a rising edge where req=1 and ready=1, latching wr, addr and wdata; the inputs are don't-care afterwards.
REQ-013 SHALL implement states IDLE, WAIT and RESP.
REQ-014 SHALL drive ready=1 in IDLE and RESP, and ready=0 in WAIT.
REQ-015 SHALL transition on accept from IDLE or RESP to WAIT, loading a counter with LATENCY-1.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP when the counter equals 0.
REQ-017 SHALL, in RESP, drive ack=1 for exactly one cycle, then go to IDLE, or to WAIT if a new request is accepted that cycle.
REQ-018 SHALL assert ack exactly LATENCY cycles after the accepting edge; back-to-back throughput is one request per LATENCY cycles.
REQ-019 SHALL perform a write to the array on the edge entering RESP; a read SHALL present mem[index] on rdata during RESP.
REQ-020 SHALL drive rdata=0 in all cycles without a read ack; for a write ack, rdata SHALL be 0.
REQ-021 SHALL ignore req while in WAIT (no queuing); deassertion of req after acceptance SHALL NOT cancel the operation.
REQ-022 SHALL, when a request to the same word is accepted in RESP after a write, return the newly written value.

Reset
REQ-023 SHALL, on rst=0, asynchronously force state=IDLE, counter=0, ack=0, rdata=0 and ready=1 (after release).
REQ-024 SHALL, if reset occurs mid-operation, abort the in-flight request with no ack and no array write.
REQ-025 SHALL NOT clear the memory array on reset; its contents are retained.

Configuration
REQ-026 SHALL support macro DMEM_WBUF_EN enabling a one-entry posted write buffer.
REQ-027 SHALL, with DMEM_WBUF_EN defined, ack an accepted write on the next cycle (latency 1) and store it in the buffer (valid, index, data), which commits to the array LATENCY cycles after acceptance.
REQ-028 SHALL, with DMEM_WBUF_EN defined, hold ready=0 for a write request arriving while the buffer is valid until commit; reads proceed normally.
REQ-029 SHALL, with DMEM_WBUF_EN defined, return buffer data for a read whose index matches a valid buffer entry (forwarding).
REQ-030 SHALL, with DMEM_WBUF_EN defined, discard an uncommitted buffer on reset.
REQ-031 SHALL, without DMEM_WBUF_EN, handle all writes per REQ-015..REQ-019; no buffer logic is present.

Verification
REQ-032 SHALL cover: reset, then write 0x1234 to addr 0x0010, then read 0x0010 -> each ack 4 cycles after accept, read rdata=0x1234.
REQ-033 SHALL cover: read addr 0x0011 after a write to 0x0010 -> same word, rdata=0x1234; addr 0x0810 with DEPTH_LOG2=10 -> wraps to word 8.
REQ-034 SHALL cover: req held high with a changing addr during WAIT -> ready=0, no extra accept, a single ack.
REQ-035 SHALL cover: back-to-back reads accepted in RESP -> acks spaced exactly 4 cycles apart.
REQ-036 SHALL cover: rst=0 two cycles after a write accept -> no ack; the location retains its previous value.
REQ-037 SHALL cover, with DMEM_WBUF_EN: write 0xBEEF to 0x0020, then immediate read of 0x0020 -> write ack after 1 cycle, read returns 0xBEEF; a second write stalls until commit.
